// File: rtl/st_multi_seq.sv
// Multi-register push/pop sequencer: walks a 9-bit register list in ascending order,
// streaming registers to the stack (push) or stack words back to registers/PC (pop).
module st_multi_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_pop,
  input  logic [8:0]  rlist,
  input  logic [15:0] lr_in,
  input  logic [15:0] rf_rdata,
  input  logic [15:0] dmem_rdata,
  input  logic        sp_adj_en,
  input  logic        sp_adj_sub,
  input  logic [6:0]  immed7,
  output logic        busy,
  output logic        done,
  output logic [2:0]  rf_raddr,
  output logic        rf_wr,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        pc_wr,
  output logic [15:0] pc_wdata,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_wr,
  output logic        dmem_rd,
  output logic [15:0] sp_out,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a request accepted only in the cycle busy is low; the operation
  // completes with a single-cycle done pulse, after which a new request may be accepted.
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [8:0]  mask_q;
  logic        pop_q;
  logic [3:0]  n_q;
  logic [15:0] base_q, addr_q, sp_q;
  logic        pend_valid_q;
  logic [3:0]  pend_idx_q;
  logic [3:0]  n_in;
  logic [3:0]  cur_idx;
  logic        last_beat;

  always_comb begin
    n_in = 4'd0;
    for (int i = 0; i < 9; i++) n_in = n_in + {3'b0, rlist[i]};
  end

  // Lowest remaining set bit gives the ascending transfer order.
  always_comb begin
    cur_idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (mask_q[i]) cur_idx = 4'(i);
    end
  end

  assign last_beat = ((mask_q & (mask_q - 9'd1)) == 9'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (n_in == 4'd0) ? DONE : XFER;
      XFER:  if (last_beat) state_d = pop_q ? DRAIN : DONE;
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_q       <= 9'd0;
      pop_q        <= 1'b0;
      n_q          <= 4'd0;
      base_q       <= 16'd0;
      addr_q       <= 16'd0;
      sp_q         <= 16'h0800;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= 4'd0;
    end else begin
      pend_valid_q <= (state_q == XFER) && pop_q;
      pend_idx_q   <= cur_idx;
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q <= rlist;
            pop_q  <= is_pop;
            n_q    <= n_in;
            base_q <= is_pop ? sp_q : sp_q - {12'd0, n_in};
            addr_q <= is_pop ? sp_q : sp_q - {12'd0, n_in};
          end else if (sp_adj_en) begin
            sp_q <= sp_adj_sub ? sp_q - {9'd0, immed7} : sp_q + {9'd0, immed7};
          end
        end
        XFER: begin
          mask_q <= mask_q & ~(9'd1 << cur_idx);
          addr_q <= addr_q + 16'd1;
        end
        DONE: sp_q <= pop_q ? sp_q + {12'd0, n_q} : base_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    rf_raddr   = 3'd0;
    rf_wr      = 1'b0;
    rf_waddr   = 3'd0;
    rf_wdata   = 16'd0;
    pc_wr      = 1'b0;
    pc_wdata   = 16'd0;
    dmem_addr  = 16'd0;
    dmem_wdata = 16'd0;
    dmem_wr    = 1'b0;
    dmem_rd    = 1'b0;
    if (state_q == XFER) begin
      dmem_addr = addr_q;
      if (pop_q) begin
        dmem_rd = 1'b1;
      end else begin
        dmem_wr = 1'b1;
        if (cur_idx == 4'd8) begin
          dmem_wdata = lr_in;
        end else begin
          rf_raddr   = cur_idx[2:0];
          dmem_wdata = rf_rdata;
        end
      end
    end
    // Pop data returns one cycle after its address, so writes trail the reads by a beat.
    if (pend_valid_q && (state_q == XFER || state_q == DRAIN)) begin
      if (pend_idx_q == 4'd8) begin
        pc_wr    = 1'b1;
        pc_wdata = dmem_rdata;
      end else begin
        rf_wr    = 1'b1;
        rf_waddr = pend_idx_q[2:0];
        rf_wdata = dmem_rdata;
      end
    end
  end

  assign sp_out    = sp_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_st_multi_seq.sv
// Directed bench for st_multi_seq: stack memory and register-file models around the DUT,
// per-cycle expectations for push, pop, empty list, wrap-around, busy-ignore and reset abort.
`timescale 1ns/1ps
module tb_st_multi_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, is_pop, sp_adj_en, sp_adj_sub;
  logic [8:0]  rlist;
  logic [6:0]  immed7;
  logic [15:0] lr_in, rf_rdata, dmem_rdata;
  logic        busy, done, rf_wr, pc_wr, dmem_wr, dmem_rd;
  logic [2:0]  rf_raddr, rf_waddr;
  logic [15:0] rf_wdata, pc_wdata, dmem_addr, dmem_wdata, sp_out;
  logic [1:0]  dbg_state;

  logic [15:0] mem [0:65535];
  logic [15:0] rf_src [0:7];
  logic [15:0] rf_got [0:7];
  logic [15:0] pc_got;
  logic [15:0] rdata_q;

  int pass_cnt = 0;
  int total_cnt = 0;

  st_multi_seq dut (
    .clk(clk), .resetn(resetn), .start(start), .is_pop(is_pop), .rlist(rlist),
    .lr_in(lr_in), .rf_rdata(rf_rdata), .dmem_rdata(dmem_rdata),
    .sp_adj_en(sp_adj_en), .sp_adj_sub(sp_adj_sub), .immed7(immed7),
    .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_wr(rf_wr),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_wr(pc_wr), .pc_wdata(pc_wdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wr(dmem_wr),
    .dmem_rd(dmem_rd), .sp_out(sp_out), .dbg_state(dbg_state)
  );

  // clock / models
  always #5 clk = ~clk;

  assign rf_rdata   = rf_src[rf_raddr];
  assign dmem_rdata = rdata_q;

  always @(posedge clk) begin
    if (dmem_wr) mem[dmem_addr] <= dmem_wdata;
    if (dmem_rd) rdata_q <= mem[dmem_addr];
    if (rf_wr) rf_got[rf_waddr] <= rf_wdata;
    if (pc_wr) pc_got <= pc_wdata;
  end

  function automatic logic [5:0] strb();
    return {busy, done, dmem_wr, dmem_rd, rf_wr, pc_wr};
  endfunction

  // Drives a one-cycle start, then scrambles the request inputs while the block is busy.
  task automatic issue(input logic p, input logic [8:0] l);
    start = 1'b1; is_pop = p; rlist = l;
    @(negedge clk);
    start = 1'b0; is_pop = ~p; rlist = 9'h1FF;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({strb(), dbg_state} !== 8'd0) $display("FAIL reset_strobes got=%b exp=0", {strb(), dbg_state});
    else pass_cnt++;
    total_cnt++;
    if ({dmem_addr, dmem_wdata, rf_wdata, pc_wdata, rf_raddr, rf_waddr} !== 70'd0)
      $display("FAIL reset_data got nonzero data/address outputs");
    else pass_cnt++;
    resetn = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (sp_out !== 16'h0800) $display("FAIL reset_sp got=%h exp=0800", sp_out);
    else pass_cnt++;
  endtask

  task automatic test_push();
    logic [5:0]  e_s [1:4] = '{6'b101000, 6'b101000, 6'b101000, 6'b110000};
    logic [15:0] e_a [1:4] = '{16'h07FD, 16'h07FE, 16'h07FF, 16'h0000};
    logic [15:0] e_d [1:4] = '{16'h1111, 16'h2222, 16'hBEEF, 16'h0000};
    rf_src[0] = 16'h1111; rf_src[1] = 16'h2222; lr_in = 16'hBEEF;
    issue(1'b0, 9'h103);
    for (int c = 1; c <= 4; c++) begin
      total_cnt++;
      if ({strb(), dmem_addr, dmem_wdata} !== {e_s[c], e_a[c], e_d[c]})
        $display("FAIL push_c%0d got=%b/%h/%h exp=%b/%h/%h", c, strb(), dmem_addr, dmem_wdata,
                 e_s[c], e_a[c], e_d[c]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({strb(), sp_out} !== {6'd0, 16'h07FD}) $display("FAIL push_sp got=%h exp=07FD", sp_out);
    else pass_cnt++;
    total_cnt++;
    if ({mem[16'h07FD], mem[16'h07FE], mem[16'h07FF]} !== {16'h1111, 16'h2222, 16'hBEEF})
      $display("FAIL push_mem got=%h %h %h exp=1111 2222 BEEF", mem[16'h07FD], mem[16'h07FE], mem[16'h07FF]);
    else pass_cnt++;
  endtask

  task automatic test_pop();
    logic [5:0]  e_s [1:5] = '{6'b100100, 6'b100110, 6'b100110, 6'b100001, 6'b110000};
    logic [15:0] e_a [1:5] = '{16'h07FD, 16'h07FE, 16'h07FF, 16'h0000, 16'h0000};
    logic [2:0]  e_w [1:5] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    logic [15:0] e_r [1:5] = '{16'h0000, 16'h1111, 16'h2222, 16'h0000, 16'h0000};
    logic [15:0] e_p [1:5] = '{16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    logic [1:0]  e_q [1:5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    issue(1'b1, 9'h103);
    for (int c = 1; c <= 5; c++) begin
      total_cnt++;
      if ({strb(), dmem_addr, rf_waddr, rf_wdata, pc_wdata, dbg_state} !==
          {e_s[c], e_a[c], e_w[c], e_r[c], e_p[c], e_q[c]})
        $display("FAIL pop_c%0d got=%b/%h/%0d/%h/%h/%0d exp=%b/%h/%0d/%h/%h/%0d", c, strb(), dmem_addr,
                 rf_waddr, rf_wdata, pc_wdata, dbg_state, e_s[c], e_a[c], e_w[c], e_r[c], e_p[c], e_q[c]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({sp_out, rf_got[0], rf_got[1], pc_got} !== {16'h0800, 16'h1111, 16'h2222, 16'hBEEF})
      $display("FAIL pop_result got=%h %h %h %h exp=0800 1111 2222 BEEF", sp_out, rf_got[0], rf_got[1], pc_got);
    else pass_cnt++;
  endtask

  task automatic test_empty();
    issue(1'b0, 9'h000);
    total_cnt++;
    if ({strb(), dmem_addr} !== {6'b110000, 16'h0000}) $display("FAIL empty_done got=%b exp=110000", strb());
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({strb(), sp_out} !== {6'd0, 16'h0800}) $display("FAIL empty_sp got=%b/%h exp=0/0800", strb(), sp_out);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [15:0] e_a [1:3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    sp_adj_en = 1'b1; sp_adj_sub = 1'b1; immed7 = 7'h7F;
    repeat (16) @(negedge clk);
    immed7 = 7'h0F;
    @(negedge clk);
    sp_adj_en = 1'b0;
    total_cnt++;
    if (sp_out !== 16'h0001) $display("FAIL adj_sub got=%h exp=0001", sp_out);
    else pass_cnt++;
    rf_src[0] = 16'hA000; rf_src[1] = 16'hA001; rf_src[2] = 16'hA002;
    issue(1'b0, 9'h007);
    for (int c = 1; c <= 3; c++) begin
      total_cnt++;
      if ({dmem_wr, dmem_addr, dmem_wdata} !== {1'b1, e_a[c], 16'hA000 + 16'(c - 1)})
        $display("FAIL wrap_c%0d got=%b/%h/%h exp=1/%h/%h", c, dmem_wr, dmem_addr, dmem_wdata,
                 e_a[c], 16'hA000 + 16'(c - 1));
      else pass_cnt++;
      @(negedge clk);
    end
    @(negedge clk);
    total_cnt++;
    if (sp_out !== 16'hFFFE) $display("FAIL wrap_sp got=%h exp=FFFE", sp_out);
    else pass_cnt++;
    sp_adj_en = 1'b1; sp_adj_sub = 1'b0; immed7 = 7'h7F;
    @(negedge clk);
    sp_adj_en = 1'b0;
    total_cnt++;
    if (sp_out !== 16'h007D) $display("FAIL adj_add_wrap got=%h exp=007D", sp_out);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    rf_src[0] = 16'h5A5A; rf_src[1] = 16'h6B6B;
    issue(1'b0, 9'h003);
    start = 1'b1; sp_adj_en = 1'b1; sp_adj_sub = 1'b0; immed7 = 7'h10;
    total_cnt++;
    if ({strb(), dmem_addr, dmem_wdata} !== {6'b101000, 16'h007B, 16'h5A5A})
      $display("FAIL busy_c1 got=%b/%h/%h exp=101000/007B/5A5A", strb(), dmem_addr, dmem_wdata);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b0; sp_adj_en = 1'b0;
    total_cnt++;
    if ({strb(), dmem_addr, dmem_wdata} !== {6'b101000, 16'h007C, 16'h6B6B})
      $display("FAIL busy_c2 got=%b/%h/%h exp=101000/007C/6B6B", strb(), dmem_addr, dmem_wdata);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (strb() !== 6'b110000) $display("FAIL busy_done got=%b exp=110000", strb());
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({strb(), sp_out} !== {6'd0, 16'h007B}) $display("FAIL busy_after got=%b/%h exp=0/007B", strb(), sp_out);
    else pass_cnt++;
    sp_adj_en = 1'b1; immed7 = 7'h22;
    issue(1'b0, 9'h000);
    sp_adj_en = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (sp_out !== 16'h007B) $display("FAIL adj_with_start got=%h exp=007B", sp_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 9'h01F);
    @(negedge clk);
    total_cnt++;
    if (strb() !== 6'b100110) $display("FAIL mid_pre got=%b exp=100110", strb());
    else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++;
    if ({strb(), dbg_state, dmem_addr, sp_out} !== {8'd0, 16'h0000, 16'h0800})
      $display("FAIL mid_reset got=%b/%0d/%h/%h exp=0/0/0000/0800", strb(), dbg_state, dmem_addr, sp_out);
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if ({strb(), dbg_state, sp_out} !== {8'd0, 16'h0800})
        $display("FAIL mid_release_c%0d got=%b/%0d/%h exp=0/0/0800", c, strb(), dbg_state, sp_out);
      else pass_cnt++;
    end
  endtask

  initial begin
    start = 1'b0; is_pop = 1'b0; rlist = 9'd0; lr_in = 16'd0;
    sp_adj_en = 1'b0; sp_adj_sub = 1'b0; immed7 = 7'd0;
    for (int i = 0; i < 8; i++) rf_src[i] = 16'd0;
    @(negedge clk);
    test_reset();
    test_push();
    test_pop();
    test_empty();
    test_wrap();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
